// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, sampled at mid-bit.
//
// Ports:
//   clock        system clock, all logic on the rising edge
//   reset        synchronous, active-high reset
//   serial_in    asynchronous UART line, idle high
//   o_byte       last correctly framed byte, held between frames
//   o_valid      one-cycle pulse when o_byte is updated
//   o_frame_err  one-cycle pulse when the stop bit is sampled low
//   o_busy       high whenever the receiver is not idle
//   o_state      current state encoding, for test visibility
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] o_byte,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_busy,
    output logic [2:0] o_state
);

    localparam logic [7:0] LastCount = 8'(CLKS_PER_BIT - 1);
    // Half a bit from the start edge lands every later sample at mid-bit.
    localparam logic [7:0] HalfCount = 8'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StStart    = 3'd1,
        StData     = 3'd2,
        StStop     = 3'd3,
        StCleanup  = 3'd4,
        StWaitHigh = 3'd5
    } state_e;

    state_e      state_q;
    logic        sync1_q;
    logic        rx_s;
    logic [7:0]  clock_count_q;
    logic [2:0]  bit_index_q;
    logic [7:0]  shift_q;

    // Two-stage synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync1_q <= serial_in;
            rx_s    <= sync1_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            clock_count_q <= 8'd0;
            bit_index_q   <= 3'd0;
            shift_q       <= 8'd0;
            o_byte        <= 8'd0;
            o_valid       <= 1'b0;
            o_frame_err   <= 1'b0;
        end else begin
            // Strobes are single-cycle; only STOP raises them.
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;

            case (state_q)
                StIdle: begin
                    clock_count_q <= 8'd0;
                    bit_index_q   <= 3'd0;
                    if (!rx_s) begin
                        state_q <= StStart;
                    end
                end

                StStart: begin
                    if (clock_count_q == HalfCount) begin
                        clock_count_q <= 8'd0;
                        // Line back high at mid-start-bit means a glitch.
                        state_q <= rx_s ? StIdle : StData;
                    end else begin
                        clock_count_q <= clock_count_q + 8'd1;
                    end
                end

                StData: begin
                    if (clock_count_q == LastCount) begin
                        clock_count_q         <= 8'd0;
                        shift_q[bit_index_q]  <= rx_s;
                        if (bit_index_q == 3'd7) begin
                            bit_index_q <= 3'd0;
                            state_q     <= StStop;
                        end else begin
                            bit_index_q <= bit_index_q + 3'd1;
                        end
                    end else begin
                        clock_count_q <= clock_count_q + 8'd1;
                    end
                end

                StStop: begin
                    if (clock_count_q == LastCount) begin
                        clock_count_q <= 8'd0;
                        if (rx_s) begin
                            o_byte  <= shift_q;
                            o_valid <= 1'b1;
                            state_q <= StCleanup;
                        end else begin
                            o_frame_err <= 1'b1;
                            state_q     <= StWaitHigh;
                        end
                    end else begin
                        clock_count_q <= clock_count_q + 8'd1;
                    end
                end

                StCleanup: begin
                    clock_count_q <= 8'd0;
                    bit_index_q   <= 3'd0;
                    state_q       <= StIdle;
                end

                StWaitHigh: begin
                    // Hold off until the line idles so a break is not read as 0x00 bytes.
                    clock_count_q <= 8'd0;
                    bit_index_q   <= 3'd0;
                    if (rx_s) begin
                        state_q <= StIdle;
                    end
                end

                default: begin
                    clock_count_q <= 8'd0;
                    bit_index_q   <= 3'd0;
                    state_q       <= StIdle;
                end
            endcase
        end
    end

    assign o_busy  = (state_q != StIdle);
    assign o_state = state_q;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    typedef struct {
        logic       err;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       serial_in;
    logic       serial7;
    logic [7:0] o_byte,  o_byte7;
    logic       o_valid, o_valid7;
    logic       o_frame_err, o_frame_err7;
    logic       o_busy,  o_busy7;
    logic [2:0] o_state, o_state7;

    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    logic [7:0] last_good = 8'h00;
    exp_t       q[$];
    exp_t       q7[$];

    uart_rx #(.CLKS_PER_BIT(20)) dut (
        .clock       (clock),
        .reset       (reset),
        .serial_in   (serial_in),
        .o_byte      (o_byte),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err),
        .o_busy      (o_busy),
        .o_state     (o_state)
    );

    uart_rx #(.CLKS_PER_BIT(7)) dut7 (
        .clock       (clock),
        .reset       (reset),
        .serial_in   (serial7),
        .o_byte      (o_byte7),
        .o_valid     (o_valid7),
        .o_frame_err (o_frame_err7),
        .o_busy      (o_busy7),
        .o_state     (o_state7)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each strobe pops the oldest expected event.
    always @(negedge clock) begin
        exp_t e;
        if (o_valid || o_frame_err) begin
            check("exclusive strobes", {31'd0, o_valid & o_frame_err}, 32'd0);
            if (q.size() == 0) begin
                check("unexpected strobe", {30'd0, o_valid, o_frame_err}, 32'd0);
            end else begin
                e = q.pop_front();
                check("strobe kind", {31'd0, o_frame_err}, {31'd0, e.err});
                check("strobe byte", {24'd0, o_byte}, {24'd0, e.data});
                check("strobe cycle", cyc, e.cyc);
            end
        end
        if (o_valid7 || o_frame_err7) begin
            if (q7.size() == 0) begin
                check("unexpected strobe7", {30'd0, o_valid7, o_frame_err7}, 32'd0);
            end else begin
                e = q7.pop_front();
                check("strobe7 kind", {31'd0, o_frame_err7}, {31'd0, e.err});
                check("strobe7 byte", {24'd0, o_byte7}, {24'd0, e.data});
                check("strobe7 cycle", cyc, e.cyc);
            end
        end
    end

    // Drives one 8N1 frame starting at a negedge; k is the first edge that samples the start bit.
    // abort_at >= 0 pulses reset at that cycle offset and abandons the frame.
    task automatic send_frame(input logic [7:0] data, input logic stop, input int abort_at,
                              input bit chk_busy, input bit sel7);
        logic [9:0] frame;
        int         cpb;
        int         k;
        int         off;
        exp_t       e;
        frame = {stop, data, 1'b0};
        cpb = sel7 ? 7 : 20;
        k = cyc + 1;
        if (abort_at < 0) begin
            e.err  = ~stop;
            e.data = stop ? data : last_good;
            e.cyc  = k + 2 + ((cpb - 1) / 2 + 1) + 9 * cpb;
            if (stop) last_good = data;
            if (sel7) q7.push_back(e);
            else q.push_back(e);
        end
        for (int b = 0; b < 10; b++) begin
            if (sel7) serial7 = frame[b];
            else serial_in = frame[b];
            for (int c = 0; c < cpb; c++) begin
                @(negedge clock);
                off = cyc - k;
                if (chk_busy && off < 2) check("busy before start", {31'd0, o_busy}, 32'd0);
                if (chk_busy && off == 2) check("busy at start", {31'd0, o_busy}, 32'd1);
                if (off == abort_at) begin
                    reset = 1'b1;
                    @(negedge clock);
                    reset = 1'b0;
                    serial_in = 1'b1;
                    last_good = 8'h00;
                    check("abort state", {29'd0, o_state}, 32'd0);
                    check("abort busy", {31'd0, o_busy}, 32'd0);
                    check("abort byte", {24'd0, o_byte}, 32'd0);
                    return;
                end
            end
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && (q.size() != 0 || q7.size() != 0); i++) @(negedge clock);
        check("scoreboard drained", q.size() + q7.size(), 32'd0);
    endtask

    initial begin
        int k;
        reset = 1'b1;
        serial_in = 1'b1;
        serial7 = 1'b1;
        repeat (3) @(negedge clock);
        check("reset byte", {24'd0, o_byte}, 32'd0);
        check("reset valid", {31'd0, o_valid}, 32'd0);
        check("reset frame_err", {31'd0, o_frame_err}, 32'd0);
        check("reset busy", {31'd0, o_busy}, 32'd0);
        check("reset state", {29'd0, o_state}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // Single 0xA5 frame with busy timing.
        send_frame(8'hA5, 1'b1, -1, 1'b1, 1'b0);
        wait_drain();
        repeat (3) @(negedge clock);
        check("A5 idle busy", {31'd0, o_busy}, 32'd0);
        check("A5 idle state", {29'd0, o_state}, 32'd0);
        check("A5 held byte", {24'd0, o_byte}, 32'hA5);

        // Back-to-back 0x00 then 0xFF, no idle gap.
        send_frame(8'h00, 1'b1, -1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b1, -1, 1'b0, 1'b0);
        wait_drain();
        repeat (10) @(negedge clock);

        // 5-clock low glitch on an idle line.
        serial_in = 1'b0;
        k = cyc + 1;
        repeat (5) @(negedge clock);
        serial_in = 1'b1;
        check("glitch in start", {29'd0, o_state}, 32'd1);
        check("glitch cycle", cyc, k + 4);
        repeat (30) @(negedge clock);
        check("glitch idle", {29'd0, o_state}, 32'd0);
        check("glitch byte", {24'd0, o_byte}, {24'd0, last_good});

        // Framing error then a held-low line.
        send_frame(8'h3C, 1'b0, -1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            repeat (25) @(negedge clock);
            check("wait_high state", {29'd0, o_state}, 32'd5);
        end
        serial_in = 1'b1;
        repeat (5) @(negedge clock);
        check("wait_high release", {29'd0, o_state}, 32'd0);
        check("frame_err byte kept", {24'd0, o_byte}, 32'hFF);
        wait_drain();
        send_frame(8'h3C, 1'b1, -1, 1'b0, 1'b0);
        wait_drain();
        check("3C byte", {24'd0, o_byte}, 32'h3C);
        repeat (10) @(negedge clock);

        // Reset during data bit 4, then a clean frame.
        send_frame(8'h5A, 1'b1, 100, 1'b0, 1'b0);
        repeat (30) @(negedge clock);
        check("post-abort byte", {24'd0, o_byte}, 32'd0);
        send_frame(8'h5A, 1'b1, -1, 1'b0, 1'b0);
        wait_drain();
        repeat (10) @(negedge clock);

        // Seven clocks per bit instance.
        send_frame(8'h81, 1'b1, -1, 1'b0, 1'b1);
        wait_drain();
        repeat (5) @(negedge clock);
        check("fast byte", {24'd0, o_byte7}, 32'h81);
        check("fast idle", {28'd0, o_busy7, o_state7}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
